// File: rtl/pci_pkg.sv
// pci_pkg: definitions shared by the PCI target, the bus-master devices and
// the arbiter bench.
//   CMD_MEM_READ / CMD_MEM_WRITE : C/BE# encodings used in the address phase
//   target_state_t                : target FSM states
package pci_pkg;

  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  typedef enum logic [1:0] {
    IDLE,
    CLAIM,
    DATA,
    BACKOFF
  } target_state_t;

endpackage

// File: rtl/pci_target_mem.sv
// pci_target_mem: word memory behind the PCI target.
//   clk   : bus clock
//   we    : write strobe for this edge
//   waddr : word index written
//   wdata : write data
//   be_n  : active-low byte enables, one per byte lane
//   raddr : word index read (asynchronous)
//   rdata : read data
// The array has no reset, so its contents survive a target reset.
module pci_target_mem #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be_n,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Byte lanes whose enable is high keep their old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (!be_n[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pci_target.sv
// pci_target: memory-mapped PCI target (completer).
//   CLK, RST       : bus clock, synchronous active-high reset
//   FRAME, IRDY    : active-low initiator controls
//   AD_IN, CBE     : sampled AD bus and command / active-low byte enables
//   AD_OUT, AD_OE  : read data and its output enable
//   TRDY, DEVSEL   : active-low target ready and device select
//   TS_OE          : output enable for TRDY and DEVSEL
// All outputs are registered; the tristate pads live outside this block.
module pci_target
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FRAME,
  input  logic        IRDY,
  input  logic [31:0] AD_IN,
  input  logic [3:0]  CBE,
  output logic [31:0] AD_OUT,
  output logic        AD_OE,
  output logic        TRDY,
  output logic        DEVSEL,
  output logic        TS_OE
);

  target_state_t     state;
  logic [ADDR_W-1:0] ptr;
  logic              is_read;
  logic              prev_frame;

  logic              addr_phase;
  logic              hit;
  logic              xfer;
  logic              early_end;
  logic              mem_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;

  // An address phase is only the falling edge of FRAME seen while idle, so a
  // missed transaction is ignored until the bus goes idle again.
  assign addr_phase = (state == IDLE) && !FRAME && prev_frame;
  assign hit        = (AD_IN[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]) &&
                      ((CBE == CMD_MEM_READ) || (CBE == CMD_MEM_WRITE));
  assign xfer       = (state == DATA) && !IRDY && !TRDY;
  assign early_end  = FRAME && IRDY;
  assign mem_we     = xfer && !is_read && !RST;

  // In DATA the read port looks one word ahead so AD_OUT can be reloaded on
  // the same edge that completes the current read phase.
  assign rd_addr = (state == DATA) ? ptr + ADDR_W'(1) : ptr;

  pci_target_mem #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (CLK),
    .we   (mem_we),
    .waddr(ptr),
    .wdata(AD_IN),
    .be_n (CBE),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_ff @(posedge CLK) begin
    prev_frame <= FRAME;
    if (RST) begin
      state  <= IDLE;
      DEVSEL <= 1'b1;
      TRDY   <= 1'b1;
      AD_OE  <= 1'b0;
      TS_OE  <= 1'b0;
      AD_OUT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (addr_phase && hit) begin
            state   <= CLAIM;
            DEVSEL  <= 1'b0;
            TS_OE   <= 1'b1;
            TRDY    <= 1'b1;
            ptr     <= AD_IN[ADDR_W+1:2];
            is_read <= (CBE == CMD_MEM_READ);
          end
        end
        CLAIM: begin
          if (early_end) begin
            state  <= BACKOFF;
            DEVSEL <= 1'b1;
          end else begin
            // The turnaround cycle ends here; read data is prefetched.
            state <= DATA;
            TRDY  <= 1'b0;
            AD_OE <= is_read;
            if (is_read) begin
              AD_OUT <= rd_data;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            ptr <= ptr + ADDR_W'(1);
            if (is_read) begin
              AD_OUT <= rd_data;
            end
            if (FRAME) begin
              state  <= BACKOFF;
              DEVSEL <= 1'b1;
              TRDY   <= 1'b1;
              AD_OE  <= 1'b0;
            end
          end else if (early_end) begin
            state  <= BACKOFF;
            DEVSEL <= 1'b1;
            TRDY   <= 1'b1;
            AD_OE  <= 1'b0;
          end
        end
        BACKOFF: begin
          state  <= IDLE;
          DEVSEL <= 1'b1;
          TRDY   <= 1'b1;
          AD_OE  <= 1'b0;
          TS_OE  <= 1'b0;
          AD_OUT <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pci_target.md
# pci_target

Memory-mapped PCI target (responder) for the shared bus. It is the completer-side counterpart of the bus-master devices granted by the arbiter. It decodes address phases, claims hits with DEVSEL, and moves burst data to and from an internal word memory using the TRDY/IRDY handshake. Byte enables are honoured on writes. Bus signals are presented as split in/out/enable ports; the tristate pads sit in the top level.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: base of the decoded window; aligned to the window size.
- ADDR_W, 3: word-index width; the memory holds 2**ADDR_W 32-bit words and spans 4·2**ADDR_W bytes.

Ports:
- CLK  in  1: bus clock. One clock; all logic acts on the rising edge.
- RST  in  1: reset, synchronous and active-high.
- FRAME  in  1: active-low bus FRAME#.
- IRDY  in  1: active-low initiator ready.
- AD_IN  in  32: sampled AD bus.
- CBE  in  4: command in the address phase; active-low byte enables in data phases.
- AD_OUT  out  32: read data driven onto AD.
- AD_OE  out  1: AD output enable.
- TRDY  out  1: active-low target ready.
- DEVSEL  out  1: active-low device select.
- TS_OE  out  1: output enable for TRDY and DEVSEL.

## Operation
- Commands: CMD_MEM_READ = 4'b0110 and CMD_MEM_WRITE = 4'b0111. All other commands are never claimed.
- Address phase: the first rising edge in IDLE with FRAME=0 whose previous sampled FRAME was 1.
- Hit condition: AD_IN[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2] and the command is read or write. AD_IN[1:0] is ignored, so bursts are linear.
- On a hit, latch the word pointer (AD_IN[ADDR_W+1:2]) and the direction. A miss stays in IDLE, and the block ignores that transaction until FRAME=1 is sampled.
- States:
  - IDLE: all outputs deasserted, TS_OE=0.
  - CLAIM: DEVSEL=0, TS_OE=1, TRDY=1. For a read, the memory word is prefetched into AD_OUT.
  - DATA: DEVSEL=0, TRDY=0. For a read, AD_OE=1.
  - BACKOFF: TRDY=1, DEVSEL=1, TS_OE=1, AD_OE=0.
- Transitions:
  - IDLE→CLAIM on a hit.
  - CLAIM→DATA unconditionally.
  - DATA→BACKOFF on a transfer edge with FRAME=1, which is the last data phase.
  - BACKOFF→IDLE unconditionally.
- Transfer: a rising edge in DATA with IRDY=0 and TRDY=0.
  - Write: each byte lane with CBE[i]=0 is stored into mem[ptr]; lanes with CBE[i]=1 keep their value.
  - Read: AD_OUT loads mem[ptr+1] on the same edge.
  - Either direction: ptr advances by 1.
- Wait states: in DATA with IRDY=1, the block holds ptr, AD_OUT and its outputs unchanged with no limit.
- Pointer arithmetic: ptr is ADDR_W bits and wraps from 2**ADDR_W−1 to 0. There is no disconnect.
- Master abort or early end (FRAME=1 and IRDY=1 sampled in CLAIM or DATA): go to BACKOFF with no transfer.
- RST=1 in any state: the next edge forces IDLE and the reset values. A write in progress on that edge is discarded. Memory contents are preserved through reset.

## Timing
- Reset values: DEVSEL=1, TRDY=1, AD_OE=0, TS_OE=0, AD_OUT=0, state IDLE.
- Edge numbering: the address phase is sampled at edge 0.
  - DEVSEL falls after edge 0 (fast decode).
  - TRDY falls after edge 1.
  - For a read, AD_OE=1 and AD_OUT is valid after edge 1. This leaves the turnaround cycle between edge 0 and edge 1.
- Earliest first transfer: edge 2. Single-phase transaction: DEVSEL is low for 2 cycles, then BACKOFF for 1 cycle, then IDLE. Minimum 3 cycles from the address phase to IDLE.
- Throughput: one word per cycle with zero wait states.
- Back-to-back transactions: a new address phase is accepted on the first edge after BACKOFF. FRAME=0 seen during BACKOFF is ignored.
- Registered outputs only; no combinational paths from inputs to outputs.

## Structure
- pci_pkg: CMD_MEM_READ and CMD_MEM_WRITE constants, and the target state enum (IDLE, CLAIM, DATA, BACKOFF). This package is shared with the master devices and the arbiter bench.
- Sub-module pci_target_mem:
  - 2**ADDR_W × 32 register file.
  - One synchronous write port with per-byte active-low enables.
  - One asynchronous read port addressed by ptr or ptr+1.
- pci_target holds the FSM, the decode logic and the output registers.

## Test plan
- Single write: address 32'h0000_0004, CMD 0111, data 32'hAAAA_AAAA, CBE=0000, IRDY=0 → DEVSEL low after edge 0, TRDY low after edge 1, mem[1]=AAAA_AAAA, BACKOFF, then IDLE.
- Byte-enable write: mem[2]=32'h1122_3344, then write 32'hFFFF_FFFF with CBE=1010 → mem[2]=32'h11FF_33FF.
- 3-word read burst at 32'h18 with IRDY held high for 2 cycles on the second phase:
  - AD_OUT sequence is mem[6], mem[7], mem[0] (wrap).
  - AD_OUT is held through the wait.
  - AD_OE=1 only in DATA.
- Address miss 32'h0000_0100 or command 4'b0010 → DEVSEL, TRDY and TS_OE stay 1 for the whole transaction, memory is unchanged, and the next hit is claimed normally.
- RST=1 asserted mid-burst (second data phase) → IDLE after one edge with reset output values, first word written, second word not written.
- Back-to-back write then read to the same address → the read returns the written data, and the second address phase is claimed one edge after BACKOFF.
